tt_track_stack: RTL and testbench

Parametrised stack with built-in running-maximum and running-minimum tracking. It is the successor to the fixed 32-bit/256-entry max-tracking stack and differs in these ways:
- storage is internal;
- element width, depth and signedness are configurable;
- it supports push, pop, peek and clear operations;
- every accepted request gets exactly one registered response.

It sits between a request master and downstream logic that needs the current top, max and min of the stack.

---
 rtl/tt_stack_pkg.sv | 24 ++
 rtl/tt_sp_ram.sv | 34 +++
 rtl/tt_track_stack.sv | 224 ++++++++++++++++++++++
 tb/tb_tt_track_stack.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_stack_pkg.sv
// Shared definitions for the tt_track_stack codebase.
//
// Contents:
//   OP_*      request operation encodings (ireq_op)
//   ERR_*     response error codes (oresp_error)
//   state_t   controller states: IDLE accepts requests, REFILL reloads the
//             top-of-stack registers from RAM after a pop
package tt_stack_pkg;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_PEEK  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_FULL  = 2'd1;
    localparam logic [1:0] ERR_EMPTY = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

endpackage

// File: rtl/tt_sp_ram.sv
// Single-port RAM with write enable and a one-cycle registered read.
//
// Ports:
//   iclk    clock
//   iwe     write enable; iwdata is written to iaddr on the rising edge
//   iaddr   address used for both write and read
//   iwdata  write data
//   ordata  contents of iaddr as sampled on the previous rising edge
//
// Storage is not reset; the stack only ever reads entries it has written.
module tt_sp_ram #(
    parameter int W  = 96,
    parameter int AW = 8
) (
    input  logic          iclk,
    input  logic          iwe,
    input  logic [AW-1:0] iaddr,
    input  logic [W-1:0]  iwdata,
    output logic [W-1:0]  ordata
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge iclk) begin
        if (iwe) begin
            mem[iaddr] <= iwdata;
        end
        rdata_q <= mem[iaddr];
    end

    assign ordata = rdata_q;

endmodule

// File: rtl/tt_track_stack.sv
// Stack with running maximum / minimum tracking.
//
// Every RAM entry stores {data, max_at_entry, min_at_entry}, where the
// max/min cover entries 0..that index. The current top entry is mirrored in
// registers so the live outputs never wait on the RAM. A pop exposes the
// next entry after a one-cycle REFILL that reads it back from RAM.
//
// Handshake: a request is accepted on a rising edge where ireq_valid and
// oready are both 1; the master must hold the request while oready is 0.
// Exactly one response (oresp_valid high for one cycle) follows each
// accepted request on the next edge.
//
// Ports:
//   iclk, ireset              clock, asynchronous active-high reset
//   oready                    request may be accepted this cycle
//   ireq_valid/op/push_data   request strobe, operation, push operand
//   oresp_valid/data/max/min  registered response; max/min describe the
//   oresp_error               stack contents before the operation
//   otop, omax, omin          live top element and running max/min (0 empty)
//   ovalid_top                live outputs meaningful (stack not empty)
//   ocount, oempty, ofull     occupancy
//   odbg_state                controller state (1 = REFILL)
module tt_track_stack
    import tt_stack_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 8,
    parameter int SIGNED = 0
) (
    input  logic          iclk,
    input  logic          ireset,
    output logic          oready,
    input  logic          ireq_valid,
    input  logic [1:0]    ireq_op,
    input  logic [DW-1:0] ireq_push_data,
    output logic          oresp_valid,
    output logic [DW-1:0] oresp_data,
    output logic [DW-1:0] oresp_max,
    output logic [DW-1:0] oresp_min,
    output logic [1:0]    oresp_error,
    output logic [DW-1:0] otop,
    output logic [DW-1:0] omax,
    output logic [DW-1:0] omin,
    output logic          ovalid_top,
    output logic [AW:0]   ocount,
    output logic          oempty,
    output logic          ofull,
    output logic          odbg_state
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE      = 1;
    localparam logic [AW:0] TWO      = 2;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] top_data_q, top_data_d;
    logic [DW-1:0] top_max_q, top_max_d;
    logic [DW-1:0] top_min_q, top_min_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic [DW-1:0] resp_max_q, resp_max_d;
    logic [DW-1:0] resp_min_q, resp_min_d;
    logic [1:0]    resp_error_q, resp_error_d;

    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [3*DW-1:0] ram_wdata;
    logic [3*DW-1:0] ram_rdata;

    logic          is_empty, is_full, accept;
    logic [DW-1:0] new_max, new_min;
    logic [AW:0]   cnt_m2;

    function automatic logic greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED != 0) begin
            greater = $signed(a) > $signed(b);
        end else begin
            greater = a > b;
        end
    endfunction

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign accept   = ireq_valid && (state_q == ST_IDLE);
    assign cnt_m2   = count_q - TWO;

    // Strict comparisons: an equal value leaves the tracked extreme alone.
    assign new_max = (is_empty || greater(ireq_push_data, top_max_q)) ? ireq_push_data : top_max_q;
    assign new_min = (is_empty || greater(top_min_q, ireq_push_data)) ? ireq_push_data : top_min_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        top_data_d   = top_data_q;
        top_max_d    = top_max_q;
        top_min_d    = top_min_q;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_max_d   = '0;
        resp_min_d   = '0;
        resp_error_d = ERR_OK;
        ram_we       = 1'b0;
        ram_addr     = count_q[AW-1:0];
        ram_wdata    = {ireq_push_data, new_max, new_min};

        case (state_q)
            ST_REFILL: begin
                // The read issued by the pop has landed; it is the new top.
                {top_data_d, top_max_d, top_min_d} = ram_rdata;
                state_d = ST_IDLE;
            end
            default: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    case (ireq_op)
                        OP_PUSH: begin
                            if (is_full) begin
                                resp_error_d = ERR_FULL;
                            end else begin
                                resp_max_d = top_max_q;
                                resp_min_d = top_min_q;
                                ram_we     = 1'b1;
                                top_data_d = ireq_push_data;
                                top_max_d  = new_max;
                                top_min_d  = new_min;
                                count_d    = count_q + ONE;
                            end
                        end
                        OP_POP: begin
                            if (is_empty) begin
                                resp_error_d = ERR_EMPTY;
                            end else begin
                                resp_data_d = top_data_q;
                                resp_max_d  = top_max_q;
                                resp_min_d  = top_min_q;
                                count_d     = count_q - ONE;
                                if (count_q == ONE) begin
                                    top_data_d = '0;
                                    top_max_d  = '0;
                                    top_min_d  = '0;
                                end else begin
                                    ram_addr = cnt_m2[AW-1:0];
                                    state_d  = ST_REFILL;
                                end
                            end
                        end
                        OP_PEEK: begin
                            if (is_empty) begin
                                resp_error_d = ERR_EMPTY;
                            end else begin
                                resp_data_d = top_data_q;
                                resp_max_d  = top_max_q;
                                resp_min_d  = top_min_q;
                            end
                        end
                        OP_CLEAR: begin
                            // RAM is left as is; count alone defines validity.
                            resp_max_d = top_max_q;
                            resp_min_d = top_min_q;
                            count_d    = '0;
                            top_data_d = '0;
                            top_max_d  = '0;
                            top_min_d  = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            top_data_q   <= '0;
            top_max_q    <= '0;
            top_min_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_max_q   <= '0;
            resp_min_q   <= '0;
            resp_error_q <= ERR_OK;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            top_data_q   <= top_data_d;
            top_max_q    <= top_max_d;
            top_min_q    <= top_min_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_max_q   <= resp_max_d;
            resp_min_q   <= resp_min_d;
            resp_error_q <= resp_error_d;
        end
    end

    tt_sp_ram #(
        .W  (3*DW),
        .AW (AW)
    ) u_ram (
        .iclk   (iclk),
        .iwe    (ram_we),
        .iaddr  (ram_addr),
        .iwdata (ram_wdata),
        .ordata (ram_rdata)
    );

    assign oready      = (state_q == ST_IDLE);
    assign oresp_valid = resp_valid_q;
    assign oresp_data  = resp_data_q;
    assign oresp_max   = resp_max_q;
    assign oresp_min   = resp_min_q;
    assign oresp_error = resp_error_q;
    assign otop        = top_data_q;
    assign omax        = top_max_q;
    assign omin        = top_min_q;
    assign ocount      = count_q;
    assign oempty      = is_empty;
    assign ofull       = is_full;
    assign ovalid_top  = ~is_empty;
    assign odbg_state  = (state_q == ST_REFILL);

endmodule

// File: tb/tb_tt_track_stack.sv
// Bench for tt_track_stack: DW=8, AW=2. Two instances share all stimulus,
// u0 with unsigned and u1 with signed max/min comparison.
module tb_tt_track_stack;
  import tt_stack_pkg::*;

  logic iclk = 1'b0;
  logic ireset;
  logic ireq_valid;
  logic [1:0] ireq_op;
  logic [7:0] ireq_push_data;

  logic [1:0] oready_w, oresp_valid_w, ovalid_top_w, oempty_w, ofull_w, dbg_w;
  logic [1:0][7:0] oresp_data_w, oresp_max_w, oresp_min_w, otop_w, omax_w, omin_w;
  logic [1:0][1:0] oresp_error_w;
  logic [1:0][2:0] ocount_w;

  int errors = 0;
  int checks = 0;

  // reference model: plain queue of stored values, bottom at index 0
  logic [7:0] mq[$];
  logic [25:0] exp_q[$];

  tt_track_stack #(.DW(8), .AW(2), .SIGNED(0)) u0 (
    .iclk(iclk), .ireset(ireset), .oready(oready_w[0]),
    .ireq_valid(ireq_valid), .ireq_op(ireq_op), .ireq_push_data(ireq_push_data),
    .oresp_valid(oresp_valid_w[0]), .oresp_data(oresp_data_w[0]),
    .oresp_max(oresp_max_w[0]), .oresp_min(oresp_min_w[0]), .oresp_error(oresp_error_w[0]),
    .otop(otop_w[0]), .omax(omax_w[0]), .omin(omin_w[0]), .ovalid_top(ovalid_top_w[0]),
    .ocount(ocount_w[0]), .oempty(oempty_w[0]), .ofull(ofull_w[0]), .odbg_state(dbg_w[0])
  );

  tt_track_stack #(.DW(8), .AW(2), .SIGNED(1)) u1 (
    .iclk(iclk), .ireset(ireset), .oready(oready_w[1]),
    .ireq_valid(ireq_valid), .ireq_op(ireq_op), .ireq_push_data(ireq_push_data),
    .oresp_valid(oresp_valid_w[1]), .oresp_data(oresp_data_w[1]),
    .oresp_max(oresp_max_w[1]), .oresp_min(oresp_min_w[1]), .oresp_error(oresp_error_w[1]),
    .otop(otop_w[1]), .omax(omax_w[1]), .omin(omin_w[1]), .ovalid_top(ovalid_top_w[1]),
    .ocount(ocount_w[1]), .oempty(oempty_w[1]), .ofull(ofull_w[1]), .odbg_state(dbg_w[1])
  );

  // clock / watchdog
  always #5 iclk = ~iclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // model helpers: extremes recomputed from the whole queue every time
  function automatic logic [7:0] m_max(input int sgn);
    logic [7:0] m;
    if (mq.size() == 0) return 8'h00;
    m = mq[0];
    foreach (mq[i]) if (sgn != 0 ? ($signed(mq[i]) > $signed(m)) : (mq[i] > m)) m = mq[i];
    return m;
  endfunction

  function automatic logic [7:0] m_min(input int sgn);
    logic [7:0] m;
    if (mq.size() == 0) return 8'h00;
    m = mq[0];
    foreach (mq[i]) if (sgn != 0 ? ($signed(mq[i]) < $signed(m)) : (mq[i] < m)) m = mq[i];
    return m;
  endfunction

  function automatic logic [7:0] m_top();
    if (mq.size() == 0) return 8'h00;
    return mq[mq.size()-1];
  endfunction

  // expected response word {data, max, min, error}
  function automatic logic [25:0] m_resp(input logic [1:0] op, input int sgn);
    case (op)
      OP_PUSH:  return (mq.size() == 4) ? {24'h0, ERR_FULL} : {8'h00, m_max(sgn), m_min(sgn), ERR_OK};
      OP_CLEAR: return {8'h00, m_max(sgn), m_min(sgn), ERR_OK};
      default:  return (mq.size() == 0) ? {24'h0, ERR_EMPTY} : {m_top(), m_max(sgn), m_min(sgn), ERR_OK};
    endcase
  endfunction

  task automatic m_apply(input logic [1:0] op, input logic [7:0] d);
    case (op)
      OP_PUSH:  if (mq.size() < 4) mq.push_back(d);
      OP_POP:   if (mq.size() > 0) void'(mq.pop_back());
      OP_CLEAR: mq.delete();
      default: ;
    endcase
  endtask

  // driver: waits for oready (bounded), presents one request for one edge,
  // returns #1 after the accepting edge with ireq_valid dropped
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int waited = 0;
    while (oready_w[0] !== 1'b1 && waited < 8) begin
      @(posedge iclk); #1;
      waited++;
    end
    checks++;
    if (waited >= 8) begin
      errors++;
      $display("FAIL ready_timeout: oready=%b after %0d cycles, required 1", oready_w[0], waited);
    end
    ireq_valid = 1'b1;
    ireq_op = op;
    ireq_push_data = d;
    @(posedge iclk); #1;
    ireq_valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge iclk); #1;
  endtask

  task automatic test_reset();
    ireset = 1'b1;
    ireq_valid = 1'b0;
    ireq_op = OP_PUSH;
    ireq_push_data = 8'h00;
    repeat (3) @(posedge iclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (oready_w[k] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b exp 1", k, oready_w[k]); end
      checks++; if (oresp_valid_w[k] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d]: got %b exp 0", k, oresp_valid_w[k]); end
      checks++; if (ocount_w[k] !== 3'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d exp 0", k, ocount_w[k]); end
      checks++; if ({oempty_w[k], ofull_w[k], ovalid_top_w[k]} !== 3'b100) begin errors++; $display("FAIL reset_flags[%0d]: got %b exp 100", k, {oempty_w[k], ofull_w[k], ovalid_top_w[k]}); end
      checks++; if ({otop_w[k], omax_w[k], omin_w[k]} !== 24'h0) begin errors++; $display("FAIL reset_live[%0d]: got %h exp 000000", k, {otop_w[k], omax_w[k], omin_w[k]}); end
      checks++; if ({oresp_data_w[k], oresp_max_w[k], oresp_min_w[k], oresp_error_w[k]} !== 26'h0) begin errors++; $display("FAIL reset_resp[%0d]: got %h exp 0", k, {oresp_data_w[k], oresp_max_w[k], oresp_min_w[k], oresp_error_w[k]}); end
    end
    @(negedge iclk);
    ireset = 1'b0;
    mq.delete();
  endtask

  task automatic test_push_pop();
    logic [7:0] vals[3];
    vals[0] = 8'd5; vals[1] = 8'd3; vals[2] = 8'd9;
    for (int i = 0; i < 3; i++) begin
      issue(OP_PUSH, vals[i]);
      m_apply(OP_PUSH, vals[i]);
      checks++; if ({oresp_valid_w[0], oresp_error_w[0]} !== {1'b1, ERR_OK}) begin errors++; $display("FAIL push_resp%0d: got valid/err %b/%0d exp 1/0", i, oresp_valid_w[0], oresp_error_w[0]); end
    end
    checks++; if ({otop_w[0], omax_w[0], omin_w[0]} !== {8'd9, 8'd9, 8'd3}) begin errors++; $display("FAIL push_live: got %h exp 090903", {otop_w[0], omax_w[0], omin_w[0]}); end
    checks++; if (ocount_w[0] !== 3'd3) begin errors++; $display("FAIL push_count: got %0d exp 3", ocount_w[0]); end
    issue(OP_POP, 8'h00);
    m_apply(OP_POP, 8'h00);
    checks++; if ({oresp_valid_w[0], oresp_data_w[0], oresp_max_w[0], oresp_min_w[0]} !== {1'b1, 8'd9, 8'd9, 8'd3}) begin errors++; $display("FAIL pop_resp: got %h exp 1090903", {oresp_valid_w[0], oresp_data_w[0], oresp_max_w[0], oresp_min_w[0]}); end
    checks++; if (oready_w[0] !== 1'b0) begin errors++; $display("FAIL pop_refill_ready: got %b exp 0", oready_w[0]); end
    settle();
    checks++; if (oready_w[0] !== 1'b1) begin errors++; $display("FAIL pop_ready_back: got %b exp 1", oready_w[0]); end
    checks++; if (oresp_valid_w[0] !== 1'b0) begin errors++; $display("FAIL pop_single_resp: got %b exp 0", oresp_valid_w[0]); end
    checks++; if ({otop_w[0], omax_w[0], omin_w[0]} !== {8'd3, 8'd5, 8'd3}) begin errors++; $display("FAIL pop_live: got %h exp 030503", {otop_w[0], omax_w[0], omin_w[0]}); end
    checks++; if (ocount_w[0] !== 3'd2) begin errors++; $display("FAIL pop_count: got %0d exp 2", ocount_w[0]); end
  endtask

  task automatic test_full();
    logic [7:0] pops[4];
    pops[0] = 8'd2; pops[1] = 8'd1; pops[2] = 8'd3; pops[3] = 8'd5;
    issue(OP_PUSH, 8'd1); m_apply(OP_PUSH, 8'd1);
    issue(OP_PUSH, 8'd2); m_apply(OP_PUSH, 8'd2);
    issue(OP_PUSH, 8'd7); m_apply(OP_PUSH, 8'd7);
    checks++; if ({oresp_valid_w[0], oresp_error_w[0]} !== {1'b1, ERR_FULL}) begin errors++; $display("FAIL full_err: got valid/err %b/%0d exp 1/1", oresp_valid_w[0], oresp_error_w[0]); end
    checks++; if ({oresp_data_w[0], oresp_max_w[0], oresp_min_w[0]} !== 24'h0) begin errors++; $display("FAIL full_resp_zero: got %h exp 000000", {oresp_data_w[0], oresp_max_w[0], oresp_min_w[0]}); end
    checks++; if ({ocount_w[0], ofull_w[0]} !== {3'd4, 1'b1}) begin errors++; $display("FAIL full_count: got count/full %0d/%b exp 4/1", ocount_w[0], ofull_w[0]); end
    checks++; if ({otop_w[0], omax_w[0], omin_w[0]} !== {8'd2, 8'd5, 8'd1}) begin errors++; $display("FAIL full_live: got %h exp 020501", {otop_w[0], omax_w[0], omin_w[0]}); end
    for (int i = 0; i < 4; i++) begin
      issue(OP_POP, 8'h00);
      m_apply(OP_POP, 8'h00);
      checks++; if (oresp_data_w[0] !== pops[i]) begin errors++; $display("FAIL drain_pop%0d: got %h exp %h", i, oresp_data_w[0], pops[i]); end
      if (i < 3) settle();
    end
    checks++; if (oready_w[0] !== 1'b1) begin errors++; $display("FAIL last_pop_no_refill: got ready %b exp 1", oready_w[0]); end
    checks++; if ({oempty_w[0], ovalid_top_w[0], ocount_w[0]} !== {1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL drain_flags: got %b exp 10000", {oempty_w[0], ovalid_top_w[0], ocount_w[0]}); end
    checks++; if ({otop_w[0], omax_w[0], omin_w[0]} !== 24'h0) begin errors++; $display("FAIL drain_live: got %h exp 000000", {otop_w[0], omax_w[0], omin_w[0]}); end
  endtask

  task automatic test_empty();
    logic [1:0] ops[2];
    ops[0] = OP_POP; ops[1] = OP_PEEK;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 8'h00);
      checks++; if ({oresp_valid_w[0], oresp_error_w[0]} !== {1'b1, ERR_EMPTY}) begin errors++; $display("FAIL empty_err op%0d: got valid/err %b/%0d exp 1/2", ops[i], oresp_valid_w[0], oresp_error_w[0]); end
      checks++; if ({oresp_data_w[0], oresp_max_w[0], oresp_min_w[0]} !== 24'h0) begin errors++; $display("FAIL empty_resp op%0d: got %h exp 000000", ops[i], {oresp_data_w[0], oresp_max_w[0], oresp_min_w[0]}); end
      checks++; if ({ocount_w[0], oready_w[0]} !== {3'd0, 1'b1}) begin errors++; $display("FAIL empty_count op%0d: got count/ready %0d/%b exp 0/1", ops[i], ocount_w[0], oready_w[0]); end
    end
  endtask

  task automatic test_signed();
    issue(OP_PUSH, 8'hFF); m_apply(OP_PUSH, 8'hFF);
    issue(OP_PUSH, 8'h01); m_apply(OP_PUSH, 8'h01);
    checks++; if ({omax_w[0], omin_w[0]} !== 16'hFF01) begin errors++; $display("FAIL unsigned_extremes: got %h exp FF01", {omax_w[0], omin_w[0]}); end
    checks++; if ({omax_w[1], omin_w[1]} !== 16'h01FF) begin errors++; $display("FAIL signed_extremes: got %h exp 01FF", {omax_w[1], omin_w[1]}); end
    checks++; if ({oresp_max_w[1], oresp_min_w[1]} !== 16'hFFFF) begin errors++; $display("FAIL signed_push_resp: got %h exp FFFF", {oresp_max_w[1], oresp_min_w[1]}); end
    issue(OP_CLEAR, 8'h00); m_apply(OP_CLEAR, 8'h00);
  endtask

  task automatic test_reset_refill();
    issue(OP_PUSH, 8'd1);
    issue(OP_PUSH, 8'd2);
    issue(OP_PUSH, 8'd3);
    issue(OP_POP, 8'h00);
    checks++; if (oready_w[0] !== 1'b0) begin errors++; $display("FAIL rr_in_refill: got ready %b exp 0", oready_w[0]); end
    ireset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if ({oready_w[k], ocount_w[k], oresp_valid_w[k]} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL rr_reset[%0d]: got ready/count/valid %b/%0d/%b exp 1/0/0", k, oready_w[k], ocount_w[k], oresp_valid_w[k]); end
      checks++; if ({otop_w[k], omax_w[k], omin_w[k]} !== 24'h0) begin errors++; $display("FAIL rr_live[%0d]: got %h exp 000000", k, {otop_w[k], omax_w[k], omin_w[k]}); end
    end
    @(negedge iclk);
    ireset = 1'b0;
    mq.delete();
  endtask

  task automatic test_clear();
    issue(OP_PUSH, 8'd1);
    issue(OP_PUSH, 8'd2);
    issue(OP_PUSH, 8'd3);
    issue(OP_CLEAR, 8'h00);
    checks++; if ({oresp_valid_w[0], oresp_error_w[0], oresp_data_w[0]} !== {1'b1, ERR_OK, 8'h00}) begin errors++; $display("FAIL clear_resp: got valid/err/data %b/%0d/%h exp 1/0/00", oresp_valid_w[0], oresp_error_w[0], oresp_data_w[0]); end
    checks++; if ({ocount_w[0], oempty_w[0]} !== {3'd0, 1'b1}) begin errors++; $display("FAIL clear_count: got count/empty %0d/%b exp 0/1", ocount_w[0], oempty_w[0]); end
    issue(OP_PUSH, 8'd4);
    checks++; if ({otop_w[0], omax_w[0], omin_w[0]} !== {8'd4, 8'd4, 8'd4}) begin errors++; $display("FAIL clear_then_push: got %h exp 040404", {otop_w[0], omax_w[0], omin_w[0]}); end
    issue(OP_CLEAR, 8'h00);
    mq.delete();
  endtask

  // random op mix, both instances against the queue model
  task automatic test_random();
    logic [1:0] op;
    logic [7:0] d;
    logic [25:0] e;
    int r, pre_size;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      op = (r < 8) ? OP_PUSH : (r < 14) ? OP_POP : (r < 19) ? OP_PEEK : OP_CLEAR;
      d = 8'($urandom_range(0, 255));
      pre_size = mq.size();
      for (int k = 0; k < 2; k++) exp_q.push_back(m_resp(op, k));
      m_apply(op, d);
      issue(op, d);
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        checks++; if (oresp_valid_w[k] !== 1'b1) begin errors++; $display("FAIL rnd_valid[%0d] n=%0d: got %b exp 1", k, n, oresp_valid_w[k]); end
        checks++; if ({oresp_data_w[k], oresp_max_w[k], oresp_min_w[k], oresp_error_w[k]} !== e) begin errors++; $display("FAIL rnd_resp[%0d] n=%0d op=%0d: got d/mx/mn/e %h/%h/%h/%0d exp %h/%h/%h/%0d", k, n, op, oresp_data_w[k], oresp_max_w[k], oresp_min_w[k], oresp_error_w[k], e[25:18], e[17:10], e[9:2], e[1:0]); end
      end
      if (op == OP_POP && pre_size > 1) begin
        checks++; if (oready_w !== 2'b00) begin errors++; $display("FAIL rnd_refill n=%0d: got ready %b exp 00", n, oready_w); end
        settle();
      end
      for (int k = 0; k < 2; k++) begin
        checks++; if ({otop_w[k], omax_w[k], omin_w[k]} !== {m_top(), m_max(k), m_min(k)}) begin errors++; $display("FAIL rnd_live[%0d] n=%0d: got %h exp %h", k, n, {otop_w[k], omax_w[k], omin_w[k]}, {m_top(), m_max(k), m_min(k)}); end
        checks++; if ({ocount_w[k], oempty_w[k], ofull_w[k], ovalid_top_w[k], oready_w[k]} !== {3'(mq.size()), mq.size() == 0, mq.size() == 4, mq.size() != 0, 1'b1}) begin errors++; $display("FAIL rnd_status[%0d] n=%0d: got count %0d flags %b exp count %0d", k, n, ocount_w[k], {oempty_w[k], ofull_w[k], ovalid_top_w[k], oready_w[k]}, mq.size()); end
      end
      if ($urandom_range(0, 3) == 0) begin
        settle();
        checks++; if (oresp_valid_w !== 2'b00) begin errors++; $display("FAIL rnd_idle n=%0d: got resp_valid %b exp 00", n, oresp_valid_w); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_empty();
    test_signed();
    test_reset_refill();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
